// File: rtl/nested_loop_counter.sv
// nested_loop_counter: a NUM_LEVELS deep nest of loop counters linked by a
// carry chain. Level 0 is the innermost loop. The bounds (and the strides in
// the optional build) are programmed while idle. Each START runs one complete
// iteration sequence, which is stepped by ADVANCE. DONE pulses after the
// final iteration.
// Optional feature macro: NESTED_LOOP_COUNTER_STRIDE_EN (per-level stride).
module nested_loop_counter #(
    parameter int NUM_LEVELS  = 3,
    parameter int COUNT_WIDTH = 8,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              CFG_WR,
    input  logic [IDX_WIDTH-1:0]              CFG_IDX,
    input  logic [COUNT_WIDTH-1:0]            CFG_MAX,
    input  logic [COUNT_WIDTH-1:0]            CFG_STRIDE,
    input  logic                              START,
    input  logic                              ADVANCE,
    output logic [NUM_LEVELS*COUNT_WIDTH-1:0] COUNT,
    output logic [NUM_LEVELS-1:0]             LAST,
    output logic                              BUSY,
    output logic                              DONE
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] count_q [NUM_LEVELS];
    logic [COUNT_WIDTH-1:0] count_d [NUM_LEVELS];
    logic [COUNT_WIDTH-1:0] max_q   [NUM_LEVELS];
    logic [COUNT_WIDTH-1:0] max_d   [NUM_LEVELS];
    logic [COUNT_WIDTH-1:0] step    [NUM_LEVELS];
    logic [NUM_LEVELS-1:0]  last;
    logic [NUM_LEVELS-1:0]  carry;
    logic                   all_last;
    logic                   chain;

`ifdef NESTED_LOOP_COUNTER_STRIDE_EN
    logic [COUNT_WIDTH-1:0] stride_q [NUM_LEVELS];
    logic [COUNT_WIDTH-1:0] stride_d [NUM_LEVELS];
`else
    logic unused_cfg_stride;
    assign unused_cfg_stride = ^CFG_STRIDE;
`endif

    // Per-level step size, final-value detect and the carry chain into each level
    always_comb begin
        chain = 1'b1;
        for (int i = 0; i < NUM_LEVELS; i++) begin
`ifdef NESTED_LOOP_COUNTER_STRIDE_EN
            step[i] = (stride_q[i] == '0) ? COUNT_WIDTH'(1) : stride_q[i];
            last[i] = ({1'b0, count_q[i]} + {1'b0, step[i]}) > {1'b0, max_q[i]};
`else
            step[i] = COUNT_WIDTH'(1);
            last[i] = (count_q[i] == max_q[i]);
`endif
            carry[i] = chain;
            chain    = chain & last[i];
        end
        all_last = chain;
    end

    // Next-state logic: configuration and START while idle, stepping while running
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        max_d   = max_q;
`ifdef NESTED_LOOP_COUNTER_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            IDLE: begin
                if (CFG_WR) begin
                    for (int i = 0; i < NUM_LEVELS; i++) begin
                        if (CFG_IDX == IDX_WIDTH'(i)) begin
                            max_d[i] = CFG_MAX;
`ifdef NESTED_LOOP_COUNTER_STRIDE_EN
                            stride_d[i] = CFG_STRIDE;
`endif
                        end
                    end
                end
                if (START) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    for (int i = 0; i < NUM_LEVELS; i++) begin
                        count_d[i] = '0;
                    end
                end
            end
            RUN: begin
                if (ADVANCE) begin
                    if (all_last) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        for (int i = 0; i < NUM_LEVELS; i++) begin
                            count_d[i] = '0;
                        end
                    end else begin
                        for (int i = 0; i < NUM_LEVELS; i++) begin
                            if (carry[i]) begin
                                count_d[i] = last[i] ? '0 : count_q[i] + step[i];
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, bounds and registered status outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_LEVELS; i++) begin
                count_q[i] <= '0;
                max_q[i]   <= '0;
`ifdef NESTED_LOOP_COUNTER_STRIDE_EN
                stride_q[i] <= COUNT_WIDTH'(1);
`endif
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_LEVELS; i++) begin
                count_q[i] <= count_d[i];
                max_q[i]   <= max_d[i];
`ifdef NESTED_LOOP_COUNTER_STRIDE_EN
                stride_q[i] <= stride_d[i];
`endif
            end
        end
    end

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_count
        assign COUNT[g*COUNT_WIDTH +: COUNT_WIDTH] = count_q[g];
    end

    assign LAST = last;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Multi-level nested loop counter. It replaces chains of single counters in the accelerator control path, e.g. output row / column / channel iteration for a convolution tile.
- NUM_LEVELS counters are linked by a carry chain. Level 0 is the innermost loop.
- Each level's wrap bound is programmed through a config write port.
- The block runs one full iteration sequence per START, gated by ADVANCE, and pulses DONE after the final iteration.

Parameters:
- NUM_LEVELS, 3, number of nested loop levels (1..8).
- COUNT_WIDTH, 8, width of each level's counter and bound.
- IDX_WIDTH, 2, width of CFG_IDX; must satisfy 2^IDX_WIDTH >= NUM_LEVELS.

Ports:
- CLK  input  1  clock.
- RESET  input  1  synchronous, active-high reset.
- CFG_WR  input  1  write CFG_MAX into bound register CFG_IDX.
- CFG_IDX  input  IDX_WIDTH  level select for config write.
- CFG_MAX  input  COUNT_WIDTH  inclusive maximum count for the selected level.
- CFG_STRIDE  input  COUNT_WIDTH  per-level stride; used only when NESTED_LOOP_COUNTER_STRIDE_EN is defined.
- START  input  1  begin an iteration sequence.
- ADVANCE  input  1  step the loop nest by one iteration.
- COUNT  output  NUM_LEVELS*COUNT_WIDTH  concatenated counts; level i occupies bits [i*COUNT_WIDTH +: COUNT_WIDTH].
- LAST  output  NUM_LEVELS  bit i high when level i is at its final value.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse on the final ADVANCE.

Behaviour:
- Reset values: all counts 0, all bounds 0, all strides 1, BUSY 0, DONE 0, state IDLE.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN on START: counts cleared to 0, BUSY=1 on the next cycle.
  - RUN -> IDLE on ADVANCE when all LAST bits are 1: DONE=1 for that one cycle (registered, visible the cycle after), counts cleared to 0.
- RUN with ADVANCE=1:
  - Level 0 steps.
  - Level i steps only when levels 0..i-1 are all LAST (carry chain, same cycle).
  - A stepping level at LAST wraps to 0. Otherwise it adds its stride (stride 1 without the optional feature).
- RUN with ADVANCE=0: all counts hold.
- LAST[i] is combinational.
  - Without stride: LAST[i] = (count_i == max_i).
  - With stride: LAST[i] = (count_i + stride_i > max_i), computed in COUNT_WIDTH+1 bits so there is no wraparound.
- Max = 0: the level is permanently LAST; effectively a pass-through for the carry.
- Max = all ones: full range; the wrap comes from LAST, not from arithmetic overflow.
- START while in RUN is ignored. ADVANCE while in IDLE is ignored.
- CFG_WR in IDLE updates the bound in the next cycle. CFG_WR while in RUN is ignored, so bounds stay stable during a sequence.
- CFG_IDX >= NUM_LEVELS: the write is dropped.
- START and CFG_WR in the same IDLE cycle: both take effect. The new bound applies from the first ADVANCE.
- RESET mid-RUN: immediate return to IDLE with all reset values. DONE is not asserted. Bounds revert to 0.
- Total ADVANCEs per sequence = product over levels of (max_i+1) without stride.
- Latency: COUNT updates one cycle after the ADVANCE edge. There is no pipelining; ADVANCE may be asserted every cycle.

Optional Feature:
- Macro: NESTED_LOOP_COUNTER_STRIDE_EN.
- Defined:
  - A per-level stride register is written together with the bound on CFG_WR, from CFG_STRIDE.
  - A stride of 0 is treated as 1.
  - The count steps by the stride; LAST uses the overflow-safe compare above.
- Undefined:
  - CFG_STRIDE is ignored and no stride registers are built.
  - Every level steps by 1 and LAST is an equality compare.

Test Plan:
- Program max {L0=2, L1=1, L2=0}, START, then ADVANCE every cycle -> COUNT sequence (L2,L1,L0) = 000,001,002,010,011,012. DONE pulses on the 6th ADVANCE, then BUSY=0 and counts return to 0.
- Same config with ADVANCE toggled 1,0,1,0 -> counts hold on the low cycles; DONE after exactly 6 asserted ADVANCEs.
- All bounds 0, START, one ADVANCE -> DONE on the first ADVANCE; LAST=3'b111 throughout.
- CFG_WR L0=5 during RUN with L0 max=2 -> ignored; sequence still wraps L0 at 2.
- RESET asserted after 3 ADVANCEs -> next cycle BUSY=0, COUNT=0, no DONE, bound readback behaviour equals max=0.
- With NESTED_LOOP_COUNTER_STRIDE_EN, L0 max=7 stride=3, L1 max=1 -> L0 sequence 0,3,6 (LAST at 6), L1 carries; DONE after 6 ADVANCEs.
